// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_en;
    logic        i_tx_done;
    logic [1:0]  o_grant_id;
    logic        o_busy;
    logic        o_timeout;

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        input  i_tx_done,
        output o_req_ready,
        output o_tx_data,
        output o_tx_en,
        output o_grant_id,
        output o_busy,
        output o_timeout
    );

    modport master (
        output i_req_valid,
        output i_req_data,
        output i_tx_done,
        input  o_req_ready,
        input  o_tx_data,
        input  o_tx_en,
        input  o_grant_id,
        input  o_busy,
        input  o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding a single UART transmitter
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int GAP_CYCLES     = 2
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    localparam logic [23:0] TIMER_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [23:0] timer_q, timer_d;
    logic [3:0]  gap_q, gap_d;

    logic        found;
    logic [1:0]  winner_idx;
    logic [3:0]  winner_oh;

    // Search starts one past the last grant; the 2-bit add wraps naturally.
    always_comb begin
        logic [1:0] cand;
        cand       = '0;
        found      = 1'b0;
        winner_idx = last_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_q + 2'(i);
            if (!found && bus.i_req_valid[cand]) begin
                found      = 1'b1;
                winner_idx = cand;
            end
        end
        winner_oh = found ? (4'b0001 << winner_idx) : 4'b0000;
    end

    assign bus.o_req_ready = (state_q == S_IDLE && rst_n) ? winner_oh : 4'b0000;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    tx_data_d = bus.i_req_data[{winner_idx, 3'b000} +: 8];
                    grant_d   = winner_idx;
                    last_d    = winner_idx;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done pulse on the final timer cycle still counts as success.
                if (bus.i_tx_done) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        tx_en_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            grant_q   <= '0;
            last_q    <= 2'd3;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
        end
    end

    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_en    = tx_en_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int TO  = 50;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .NREQ           (4),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         model_last;
    logic [7:0] req_byte [4];
    logic [3:0] req_mask;
    int         fair_order [6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.i_req_valid = req_mask;
        bus.i_req_data  = {req_byte[3], req_byte[2], req_byte[1], req_byte[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (m[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    // One full byte: arbitration, launch, done after d wait cycles (or timeout), gap.
    task automatic serve_one(input int d, input bit keep, input string tag);
        int         w;
        logic [7:0] b;
        drive();
        #1;
        w = rr_pick(req_mask, model_last);
        chk({tag, ".ready"}, {28'd0, bus.o_req_ready}, 32'(1 << w));
        b = req_byte[w];
        tick();
        chk({tag, ".tx_en"}, {31'd0, bus.o_tx_en}, 32'd1);
        chk({tag, ".tx_data"}, {24'd0, bus.o_tx_data}, {24'd0, b});
        chk({tag, ".grant"}, {30'd0, bus.o_grant_id}, 32'(w));
        chk({tag, ".ready_launch"}, {28'd0, bus.o_req_ready}, 32'd0);
        model_last = w;
        if (keep) req_byte[w] = 8'($urandom);
        else      req_mask[w] = 1'b0;
        drive();
        tick();
        chk({tag, ".tx_en_wait"}, {31'd0, bus.o_tx_en}, 32'd0);
        for (int j = 0; j < TO; j++) begin
            if (j == d) bus.i_tx_done = 1'b1;
            tick();
            bus.i_tx_done = 1'b0;
            if (j == d) break;
        end
        chk({tag, ".timeout"}, {31'd0, bus.o_timeout}, (d >= TO) ? 32'd1 : 32'd0);
        chk({tag, ".busy_gap"}, {31'd0, bus.o_busy}, 32'd1);
        tick();
        chk({tag, ".timeout_once"}, {31'd0, bus.o_timeout}, 32'd0);
        chk({tag, ".data_hold"}, {24'd0, bus.o_tx_data}, {24'd0, b});
        chk({tag, ".ready_gap"}, {28'd0, bus.o_req_ready}, 32'd0);
        tick();
        chk({tag, ".busy_idle"}, {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, {31'd0, bus.o_busy}, 32'd0);
        chk({tag, ".tx_en"}, {31'd0, bus.o_tx_en}, 32'd0);
        chk({tag, ".tx_data"}, {24'd0, bus.o_tx_data}, 32'd0);
        chk({tag, ".grant"}, {30'd0, bus.o_grant_id}, 32'd0);
        chk({tag, ".timeout"}, {31'd0, bus.o_timeout}, 32'd0);
        chk({tag, ".ready"}, {28'd0, bus.o_req_ready}, 32'd0);
    endtask

    initial begin
        bit quiet;
        rst_n         = 1'b1;
        bus.i_tx_done = 1'b0;
        req_mask      = '0;
        for (int k = 0; k < 4; k++) req_byte[k] = '0;
        drive();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("reset");
        model_last = 3;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        req_mask = 4'hF;
        for (int k = 0; k < 4; k++) req_byte[k] = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            serve_one(9, 1'b1, "fair");
            chk("fair.order", {30'd0, bus.o_grant_id}, 32'(fair_order[k]));
        end

        req_mask    = 4'b0100;
        req_byte[2] = 8'hA5;
        serve_one(3, 1'b0, "single");

        req_mask    = 4'b0001;
        req_byte[0] = 8'h3C;
        serve_one(TO + 5, 1'b0, "tmo");

        req_mask    = 4'b1000;
        req_byte[3] = 8'hC3;
        serve_one(TO - 1, 1'b0, "done_vs_tmo");

        req_mask = 4'b0000;
        drive();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("spur.busy", {31'd0, bus.o_busy}, 32'd0);
        chk("spur.ready", {28'd0, bus.o_req_ready}, 32'd0);
        chk("spur.tx_en", {31'd0, bus.o_tx_en}, 32'd0);
        tick();
        chk("spur.busy2", {31'd0, bus.o_busy}, 32'd0);

        for (int it = 0; it < 40; it++) begin
            req_mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) req_byte[k] = 8'($urandom);
            serve_one(int'($urandom_range(0, TO + 3)), 1'($urandom_range(0, 1)), "rand");
        end

        req_mask    = 4'b0010;
        req_byte[1] = 8'h5A;
        drive();
        tick();
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_wait");
        model_last = 3;
        tick();
        req_mask = 4'b0000;
        drive();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < TO + 5; c++) begin
            tick();
            if (bus.o_tx_en !== 1'b0 || bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b0) quiet = 1'b0;
        end
        chk("post_rst.quiet", {31'd0, quiet}, 32'd1);

        req_mask    = 4'b1001;
        req_byte[0] = 8'h11;
        req_byte[3] = 8'h33;
        serve_one(4, 1'b0, "post_rst");
        chk("post_rst.first_grant", {30'd0, bus.o_grant_id}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters; fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: maximum cycles spent in WAIT_DONE before abort.
REQ-003 Parameter GAP_CYCLES, default 2: idle cycles inserted after every completed or aborted byte; legal range 1..15.
REQ-004 Reset rst_n, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 i_req_valid  input  4  per-requester byte valid; bit k is requester k.
REQ-008 i_req_data  input  32  requester k byte on bits [8k+7:8k].
REQ-009 o_req_ready  output  4  one-hot accept; a transfer occurs on a clock edge where valid[k]&ready[k].
REQ-010 o_tx_data  output  8  byte to the UART transmitter.
REQ-011 o_tx_en  output  1  one-cycle launch pulse to the transmitter.
REQ-012 i_tx_done  input  1  one-cycle frame-complete pulse from the transmitter.
REQ-013 o_grant_id  output  2  index of the requester owning the current or last byte.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_timeout  output  1  one-cycle pulse on WAIT_DONE abort.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-017 IDLE: winner = first set bit of i_req_valid, searched round-robin starting at last_grant+1 (mod 4).
REQ-018 o_req_ready is combinational: one-hot winner bit while in IDLE with any valid set; all zero in all other states.
REQ-019 On the accept edge: latch winner byte into o_tx_data, load o_grant_id and last_grant with the winner, go to LAUNCH.
REQ-020 LAUNCH, exactly one cycle: o_tx_en=1 (registered); next state WAIT_DONE.
REQ-021 o_tx_en is 0 in every state except LAUNCH.
REQ-022 o_tx_data holds stable from LAUNCH through the end of GAP.
REQ-023 WAIT_DONE: 24-bit timer counts from 0 each cycle; on i_tx_done=1 go to GAP.
REQ-024 Abort: timer reaches TIMEOUT_CYCLES-1 without i_tx_done -> o_timeout=1 for one cycle, go to GAP.
REQ-025 i_tx_done and the timeout condition in the same cycle: done wins, o_timeout stays 0.
REQ-026 i_tx_done outside WAIT_DONE is ignored.
REQ-027 GAP: count GAP_CYCLES cycles, then go to IDLE; requests are not sampled during GAP.
REQ-028 Accept-to-launch latency: o_tx_en rises the cycle immediately after the accept edge.
REQ-029 Minimum byte-to-byte spacing: 1 (accept) + 1 (LAUNCH) + done latency + GAP_CYCLES.
REQ-030 Requesters keep valid and data stable until accepted; if valid drops in IDLE, arbitration is re-evaluated the same cycle.
REQ-031 Each accepted byte yields exactly one o_tx_en pulse; no accepted byte is ever dropped or duplicated.

Reset
REQ-032 Reset values: state=IDLE, o_tx_en=0, o_tx_data=0, o_grant_id=0, o_busy=0, o_timeout=0, o_req_ready=0, timers=0.
REQ-033 last_grant resets to 3, so requester 0 has first priority after reset.
REQ-034 Reset asserted mid-operation aborts immediately; no o_tx_en or o_timeout pulse follows deassertion until a new accept.

Verification
REQ-035 Single requester: valid[2]=1, data=0xA5 -> ready[2] pulses one cycle, o_tx_en pulses next cycle with o_tx_data=0xA5, o_grant_id=2; done pulse -> GAP, then IDLE after 2 cycles.
REQ-036 Fairness: all four valid held continuously, done returned 10 cycles after each launch -> grant order 0,1,2,3,0,1; each requester receives exactly one byte per 4.
REQ-037 Timeout: TIMEOUT_CYCLES=50, no done -> o_timeout pulses once, 50 cycles after WAIT_DONE entry; o_busy falls 2 cycles later.
REQ-038 Done and timeout on the same cycle -> o_timeout=0, normal GAP entry.
REQ-039 Spurious done while in IDLE -> no state change and no ready pulse.
REQ-040 rst_n low during WAIT_DONE -> all outputs at reset values; after release, valid[0] and valid[3] both set -> requester 0 granted first.
